// File: rtl/usb_hpi_sequencer.sv
// rtl/usb_hpi_sequencer.sv - HPI burst sequencer for the CY7C67200 host port
module usb_hpi_sequencer #(
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int RST_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic        hpi_rst_n,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic [15:0] hpi_data_in
);

    // HPI register selects; MAILBOX (2'b01) and STATUS (2'b11) are never driven here
    localparam logic [1:0] REG_DATA    = 2'b00;
    localparam logic [1:0] REG_ADDRESS = 2'b10;

    localparam logic [7:0] STB_LAST  = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RST_HOLD,
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP,
        S_WAIT_WR
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cnt;
    logic        r_write;
    logic        r_addr_phase;
    logic [15:0] r_words;
    logic [15:0] r_data_out;
    logic [15:0] r_rd_data;

    logic        w_drive;
    logic        w_data_rd;
    logic        w_last_word;

    // The address phase is always a write; data phases follow the command direction
    assign w_drive     = r_addr_phase | r_write;
    assign w_data_rd   = ~r_addr_phase & ~r_write;
    assign w_last_word = (r_words == 16'd1);

    assign busy         = (r_state != S_IDLE);
    assign hpi_rst_n    = (r_state != S_RST_HOLD);
    assign hpi_addr     = r_addr_phase ? REG_ADDRESS : REG_DATA;
    assign hpi_data_out = r_data_out;
    assign rd_data      = r_rd_data;

    // State register; reset aborts whatever access is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RST_HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Phase timer: restarts on every state change, runs only in timed states
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (w_next_state != r_state) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_RST_HOLD || r_state == S_STROBE || r_state == S_HOLD) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Command latch, write-data latch, read capture and burst word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_addr_phase <= 1'b0;
            r_words      <= 16'd0;
            r_data_out   <= 16'd0;
            r_rd_data    <= 16'd0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_write      <= cmd_write;
                r_addr_phase <= 1'b1;
                r_data_out   <= cmd_addr & 16'hFFFE;
                r_words      <= (cmd_len == 8'd0) ? 16'd1 : {8'd0, cmd_len};
            end
            if (r_state == S_STROBE && r_cnt == STB_LAST && w_data_rd) begin
                r_rd_data <= hpi_data_in;
            end
            if (r_state == S_GAP) begin
                if (r_addr_phase) begin
                    r_addr_phase <= 1'b0;
                end else begin
                    r_words <= r_words - 16'd1;
                end
            end
            if (r_state == S_WAIT_WR && wr_valid) begin
                r_data_out <= wr_data;
            end
        end
    end

    // Next-state and pin decode; strobes and chip select follow the state directly
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        hpi_cs_n     = 1'b1;
        hpi_rd_n     = 1'b1;
        hpi_wr_n     = 1'b1;
        hpi_data_oe  = 1'b0;
        rd_valid     = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_RST_HOLD: begin
                if (r_cnt == RST_LAST) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                hpi_cs_n     = 1'b0;
                hpi_data_oe  = w_drive;
                w_next_state = S_STROBE;
            end
            S_STROBE: begin
                hpi_cs_n    = 1'b0;
                hpi_data_oe = w_drive;
                if (w_drive) begin
                    hpi_wr_n = 1'b0;
                end else begin
                    hpi_rd_n = 1'b0;
                end
                if (r_cnt == STB_LAST) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                hpi_cs_n    = 1'b0;
                hpi_data_oe = w_drive;
                rd_valid    = w_data_rd & (r_cnt == 8'd0);
                if (r_cnt == HOLD_LAST) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (!r_addr_phase && w_last_word) begin
                    done         = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_write) begin
                    w_next_state = S_WAIT_WR;
                end else begin
                    w_next_state = S_SETUP;
                end
            end
            S_WAIT_WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    w_next_state = S_SETUP;
                end
            end
            default: begin
                w_next_state = S_RST_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_hpi_sequencer.sv
// tb/tb_usb_hpi_sequencer.sv - scoreboard bench for usb_hpi_sequencer
module tb_usb_hpi_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic        hpi_rst_n;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [15:0] hpi_data_in;

    always #5 clk = ~clk;

    usb_hpi_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n),
        .hpi_wr_n(hpi_wr_n), .hpi_rst_n(hpi_rst_n),
        .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe), .hpi_data_in(hpi_data_in)
    );

    // Chip model: presents the next word of the read table, advancing on each RD_N rise
    logic [15:0] rd_mem [0:3];
    int          rd_idx = 0;
    assign hpi_data_in = rd_mem[rd_idx[1:0]];
    always @(posedge hpi_rd_n) rd_idx = rd_idx + 1;

    // Event record: kind 0=write access, 1=read access, 2=rd_valid, 3=done
    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [7:0]  stb;
        logic [7:0]  cs;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] k, input logic [1:0] a, input logic [15:0] d,
                               input logic [7:0] s, input logic [7:0] c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.stb = s; e.cs = c;
        return e;
    endfunction

    task automatic push_wr(input logic [1:0] a, input logic [15:0] d);
        exp_q.push_back(mk(2'd0, a, d, 8'd4, 8'd7));
    endtask

    task automatic push_rd(input logic [15:0] d);
        exp_q.push_back(mk(2'd2, 2'b00, d, 8'd0, 8'd0));
        exp_q.push_back(mk(2'd1, 2'b00, 16'd0, 8'd4, 8'd7));
    endtask

    task automatic observe(input ev_t got);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
            e = exp_q.pop_front();
            check("event", 64'(got), 64'(e));
        end
    endtask

    // Monitor: rebuilds each HPI access from the pins and scores it against the queue
    logic        in_acc = 1'b0;
    logic        acc_w;
    logic [1:0]  acc_addr;
    logic [15:0] acc_data;
    int          acc_stb;
    int          acc_cs;
    always @(negedge clk) begin
        if (!hpi_rd_n && hpi_data_oe) begin
            n_miss++;
            $display("FAIL oe_during_rd: got oe=1 rd_n=0 expected oe=0");
        end
        if (!hpi_rd_n && !hpi_wr_n) begin
            n_miss++;
            $display("FAIL rd_wr_overlap: got both low expected at most one");
        end
        if (cmd_ready && busy) begin
            n_miss++;
            $display("FAIL ready_while_busy: got cmd_ready=1 busy=1 expected cmd_ready=0");
        end
        if (rd_valid) observe(mk(2'd2, 2'b00, rd_data, 8'd0, 8'd0));
        if (!hpi_cs_n) begin
            if (!in_acc) begin
                in_acc   = 1'b1;
                acc_w    = 1'b0;
                acc_addr = hpi_addr;
                acc_data = 16'd0;
                acc_stb  = 0;
                acc_cs   = 0;
            end
            acc_cs++;
            if (!hpi_wr_n) begin
                acc_stb++;
                acc_w    = 1'b1;
                acc_data = hpi_data_out;
            end
            if (!hpi_rd_n) acc_stb++;
        end else if (in_acc) begin
            in_acc = 1'b0;
            observe(mk(acc_w ? 2'd0 : 2'd1, acc_addr, acc_data, 8'(acc_stb), 8'(acc_cs)));
        end
        if (done) observe(mk(2'd3, 2'b00, 16'd0, 8'd0, 8'd0));
    end

    task automatic reset_release();
        int lo;
        reset = 1'b1;
        cmd_valid = 1'b0;
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pins",
              {hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n, hpi_data_oe, hpi_addr,
               rd_valid, done, cmd_ready, wr_ready, busy}, 12'b11100_00_00001);
        check("reset_data", {hpi_data_out, rd_data}, 32'h0);
        reset = 1'b0;
        lo = 0;
        for (int i = 0; i < 300; i++) begin
            if (hpi_rst_n) break;
            lo++;
            @(negedge clk);
        end
        check("rst_low_clks", lo, 16);
        check("idle_after_rst", {cmd_ready, busy}, 2'b10);
    endtask

    task automatic do_cmd(input logic w, input logic [15:0] a, input logic [7:0] l, input logic hold);
        logic ok;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("cmd_accept", ok, 1'b1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", ok, 1'b1);
    endtask

    task automatic wait_wr_ready();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wr_ready_seen", ok, 1'b1);
    endtask

    initial begin
        logic stall_bad;
        @(negedge clk);
        reset_release();

        // Single-word write, wr_valid held high; address LSB dropped
        @(negedge clk);
        wr_data  = 16'hBEEF;
        wr_valid = 1'b1;
        push_wr(2'b10, 16'h1000);
        push_wr(2'b00, 16'hBEEF);
        exp_q.push_back(mk(2'd3, 2'b00, 16'd0, 8'd0, 8'd0));
        do_cmd(1'b1, 16'h1001, 8'd1, 1'b0);
        check("lat_setup", {hpi_cs_n, hpi_wr_n, hpi_data_oe}, 3'b011);
        @(negedge clk);
        check("lat_strobe", {hpi_wr_n, hpi_addr}, 3'b010);
        wait_done();
        wr_valid = 1'b0;
        @(negedge clk);

        // Three-word read burst from the chip model
        rd_mem[0] = 16'h1111; rd_mem[1] = 16'h2222; rd_mem[2] = 16'h3333; rd_mem[3] = 16'h0;
        rd_idx = 0;
        push_wr(2'b10, 16'h0140);
        push_rd(16'h1111);
        push_rd(16'h2222);
        push_rd(16'h3333);
        exp_q.push_back(mk(2'd3, 2'b00, 16'd0, 8'd0, 8'd0));
        do_cmd(1'b0, 16'h0140, 8'd3, 1'b0);
        wait_done();
        @(negedge clk);
        check("idle_after_read", busy, 1'b0);

        // Two-word write with a 10-clock stall before the second word
        wr_data  = 16'hA5A5;
        wr_valid = 1'b1;
        push_wr(2'b10, 16'h2002);
        push_wr(2'b00, 16'hA5A5);
        push_wr(2'b00, 16'h5A5A);
        exp_q.push_back(mk(2'd3, 2'b00, 16'd0, 8'd0, 8'd0));
        do_cmd(1'b1, 16'h2002, 8'd2, 1'b0);
        wait_wr_ready();
        @(negedge clk);
        wr_valid = 1'b0;
        check("wr_latched", hpi_data_out, 16'hA5A5);
        wait_wr_ready();
        stall_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!hpi_cs_n || !wr_ready) stall_bad = 1'b1;
            @(negedge clk);
        end
        check("stall_cs_high", stall_bad, 1'b0);
        wr_data  = 16'h5A5A;
        wr_valid = 1'b1;
        wait_done();
        wr_valid = 1'b0;
        @(negedge clk);

        // Zero-length read counts as one word; cmd_valid held through the burst
        rd_mem[0] = 16'h4444;
        rd_idx = 0;
        push_wr(2'b10, 16'h0006);
        push_rd(16'h4444);
        exp_q.push_back(mk(2'd3, 2'b00, 16'd0, 8'd0, 8'd0));
        do_cmd(1'b0, 16'h0007, 8'd0, 1'b1);
        wait_done();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("no_accept_after_done", {busy, cmd_ready}, 2'b01);

        // Reset in the second strobe clock of an address write
        exp_q.push_back(mk(2'd0, 2'b10, 16'h3000, 8'd2, 8'd3));
        do_cmd(1'b1, 16'h3000, 8'd1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (!hpi_wr_n) break;
            @(negedge clk);
        end
        check("abort_in_strobe", hpi_wr_n, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_pins", {hpi_wr_n, hpi_cs_n, hpi_data_oe, hpi_rst_n}, 4'b1100);
        reset_release();

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
